// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one registered one-hot control word to an external ALU,
// waits a fixed number of settle cycles (longer for multiply/divide), captures the
// ALU's high/low results and raises a one-cycle done pulse. A request whose op
// is not exactly one-hot is rejected with done and err, and nothing else changes.
module alu_sequencer #(
  parameter int BITS        = 32,
  parameter int SIG_COUNT   = 12,
  parameter int MULDIV_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [SIG_COUNT-1:0] op,
  input  logic [BITS-1:0]      alu_hi,
  input  logic [BITS-1:0]      alu_lo,
  output logic [SIG_COUNT-1:0] alu_ctrl,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [BITS-1:0]      z_hi,
  output logic [BITS-1:0]      z_lo
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  // Extra cycles spent in EXEC before the capture edge for multiply/divide.
  localparam logic [3:0]           MD_LOAD = 4'(MULDIV_WAIT - 1);
  localparam logic [SIG_COUNT-1:0] OP_ONE  = SIG_COUNT'(1);

  logic [0:0] state;
  logic [3:0] cnt;
  logic       op_onehot;
  logic       op_muldiv;
  logic       ctrl_muldiv;

  // A value is one-hot when it is nonzero and clearing its lowest set bit leaves zero.
  assign op_onehot   = (op != '0) && ((op & (op - OP_ONE)) == '0);
  assign op_muldiv   = op[2] | op[3];
  // The latched control word, not the live op input, decides how z_hi is filled.
  assign ctrl_muldiv = alu_ctrl[2] | alu_ctrl[3];

  // Request acceptance, settle countdown and result capture.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would let later statements observe half-updated state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      cnt      <= '0;
      alu_ctrl <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      z_hi     <= '0;
      z_lo     <= '0;
    end else begin
      // done/err are single-cycle pulses unless re-raised below.
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op_onehot) begin
              alu_ctrl <= op;
              busy     <= 1'b1;
              cnt      <= op_muldiv ? MD_LOAD : 4'd0;
              state    <= EXEC;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        EXEC: begin
          // start and op are deliberately not looked at while busy.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            z_lo     <= alu_lo;
            z_hi     <= ctrl_muldiv ? alu_hi : '0;
            done     <= 1'b1;
            busy     <= 1'b0;
            alu_ctrl <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
